// File: rtl/fp_add_control.sv
// Sequencing FSM for the floating-point adder: alignment, normalisation, rounding and re-normalisation.
// Optional macro CONTROL_ZERO_BYPASS_EN: a zero sum skips rounding and finishes straight from NORM.
module fp_add_control #(
    parameter  int EXPBITS      = 8,
    parameter  int MANTISSABITS = 23,
    localparam int NBITS        = $clog2(MANTISSABITS),
    localparam int NBITSE       = $clog2(2*MANTISSABITS)
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Go,
    input  logic                      ExpSet,
    input  logic [EXPBITS-1:0]        ExpDiff,
    input  logic                      FFOValid,
    input  logic [NBITS-1:0]          FFOIndex,
    input  logic [MANTISSABITS+1:0]   roundedMant,
    output logic                      SelExpMux,
    output logic                      SelSRMuxL,
    output logic                      SelSRMuxG,
    output logic                      ShiftRightEnable,
    output logic [NBITSE-1:0]         ShiftRightAmount,
    output logic [NBITS-1:0]          ShiftAmount,
    output logic                      SREn,
    output logic                      SLEn,
    output logic                      NoShift,
    output logic                      SelMuxR,
    output logic                      Ready
);

    // state  | meaning
    // IDLE   | waiting for Go, all outputs low
    // ALIGN  | steer exponent/mantissa muxes, drive alignment shift
    // NORM   | normalise adder sum from the FFO leading-one index
    // ROUND  | rounder working; carry-out forces a re-normalise
    // RENORM | shift rounded mantissa right by one
    // DONE   | Ready pulse; Go here chains straight into ALIGN
    typedef enum logic [2:0] {
        S_IDLE, S_ALIGN, S_NORM, S_ROUND, S_RENORM, S_DONE
    } state_t;

    localparam int H = MANTISSABITS;
    localparam logic [NBITSE-1:0]  ALIGN_SAT  = NBITSE'(H + 2);
    localparam logic [EXPBITS-1:0] DIFF_SAT   = EXPBITS'(H + 2);
    localparam logic [NBITS-1:0]   IDX_HIDDEN = NBITS'(H);
    localparam logic [NBITS-1:0]   IDX_CARRY  = NBITS'(H + 1);

    state_t state, state_nxt;

    // Only the carry bit of the rounder output steers the sequence.
    logic rounded_unused;
    assign rounded_unused = ^roundedMant[H:0];

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        SelExpMux        = 1'b0;
        SelSRMuxL        = 1'b0;
        SelSRMuxG        = 1'b0;
        ShiftRightEnable = 1'b0;
        ShiftRightAmount = '0;
        ShiftAmount      = '0;
        SREn             = 1'b0;
        SLEn             = 1'b0;
        NoShift          = 1'b0;
        SelMuxR          = 1'b0;
        Ready            = 1'b0;
        case (state)
            S_IDLE: begin
                if (Go) state_nxt = S_ALIGN;
            end
            S_ALIGN: begin
                ShiftRightEnable = 1'b1;
                SelExpMux        = ExpSet;
                SelSRMuxL        = ExpSet;
                SelSRMuxG        = ExpSet;
                // Beyond H+2 every bit incl. guard falls out, so further shift is pointless.
                ShiftRightAmount = (ExpDiff > DIFF_SAT) ? ALIGN_SAT : NBITSE'(ExpDiff);
                state_nxt        = S_NORM;
            end
            S_NORM: begin
                if (!FFOValid) begin
                    NoShift = 1'b1;
                end else if (FFOIndex == IDX_CARRY) begin
                    SREn        = 1'b1;
                    ShiftAmount = NBITS'(1);
                end else if (FFOIndex < IDX_HIDDEN) begin
                    SLEn        = 1'b1;
                    ShiftAmount = IDX_HIDDEN - FFOIndex;
                end else begin
                    NoShift = 1'b1;
                end
`ifdef CONTROL_ZERO_BYPASS_EN
                state_nxt = FFOValid ? S_ROUND : S_DONE;
`else
                state_nxt = S_ROUND;
`endif
            end
            S_ROUND: begin
                state_nxt = roundedMant[H+1] ? S_RENORM : S_DONE;
            end
            S_RENORM: begin
                SelMuxR     = 1'b1;
                SREn        = 1'b1;
                ShiftAmount = NBITS'(1);
                state_nxt   = S_ROUND;
            end
            S_DONE: begin
                Ready     = 1'b1;
                state_nxt = Go ? S_ALIGN : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fp_add_control.sv
// Self-checking bench for fp_add_control: directed table, random operations against a per-cycle reference.
// Honours CONTROL_ZERO_BYPASS_EN when building expectations.
module tb_fp_add_control;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Go = 1'b0, ExpSet = 1'b0, FFOValid = 1'b0;
    logic [7:0]  ExpDiff = '0;
    logic [4:0]  FFOIndex = '0;
    logic [24:0] roundedMant = '0;
    logic        SelExpMux, SelSRMuxL, SelSRMuxG, ShiftRightEnable;
    logic [5:0]  ShiftRightAmount;
    logic [4:0]  ShiftAmount;
    logic        SREn, SLEn, NoShift, SelMuxR, Ready;

    fp_add_control dut (
        .Clock(Clock), .Reset(Reset), .Go(Go), .ExpSet(ExpSet), .ExpDiff(ExpDiff),
        .FFOValid(FFOValid), .FFOIndex(FFOIndex), .roundedMant(roundedMant),
        .SelExpMux(SelExpMux), .SelSRMuxL(SelSRMuxL), .SelSRMuxG(SelSRMuxG),
        .ShiftRightEnable(ShiftRightEnable), .ShiftRightAmount(ShiftRightAmount),
        .ShiftAmount(ShiftAmount), .SREn(SREn), .SLEn(SLEn), .NoShift(NoShift),
        .SelMuxR(SelMuxR), .Ready(Ready)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic       sel_exp, sel_l, sel_g, sre;
        logic [5:0] sra;
        logic [4:0] sa;
        logic       sr, sl, ns, smr, rdy;
    } out_t;

    typedef struct {
        bit from_idle;
        bit es;
        int ed;
        bit fv;
        int fi;
        int nc;
        bit chain;
        int lat;
    } vec_t;

`ifdef CONTROL_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    int   n_vec = 0;
    int   n_err = 0;
    out_t exp_q[$];
    int   carry_q[$];
    vec_t tbl[10];

    task automatic check(input out_t e, input string nm);
        out_t got;
        got = '{SelExpMux, SelSRMuxL, SelSRMuxG, ShiftRightEnable, ShiftRightAmount,
                ShiftAmount, SREn, SLEn, NoShift, SelMuxR, Ready};
        n_vec++;
        if (got !== e) begin
            n_err++;
            $display("FAIL %s at %0t: got %05h expected %05h", nm, $time, got, e);
        end
    endtask

    // Expected outputs cycle by cycle from ALIGN to DONE, plus the rounder carry to drive (-1: any).
    function automatic void model(input vec_t v);
        out_t o;
        exp_q.delete();
        carry_q.delete();
        o = '0;
        o.sel_exp = v.es; o.sel_l = v.es; o.sel_g = v.es; o.sre = 1'b1;
        o.sra = 6'((v.ed > 25) ? 25 : v.ed);
        exp_q.push_back(o); carry_q.push_back(-1);
        o = '0;
        if (!v.fv)          o.ns = 1'b1;
        else if (v.fi == 24) begin o.sr = 1'b1; o.sa = 5'd1; end
        else if (v.fi < 23)  begin o.sl = 1'b1; o.sa = 5'(23 - v.fi); end
        else                o.ns = 1'b1;
        exp_q.push_back(o); carry_q.push_back(-1);
        if (!(BYP && !v.fv)) begin
            for (int k = 0; k < v.nc; k++) begin
                exp_q.push_back('0); carry_q.push_back(1);
                o = '0; o.smr = 1'b1; o.sr = 1'b1; o.sa = 5'd1;
                exp_q.push_back(o); carry_q.push_back(-1);
            end
            exp_q.push_back('0); carry_q.push_back(0);
        end
        o = '0; o.rdy = 1'b1;
        exp_q.push_back(o); carry_q.push_back(-1);
    endfunction

    task automatic drive_cycle(input vec_t v, input int c, input int n);
        logic [24:0] rm;
        ExpSet   = (c == 0) ? v.es : 1'($urandom);
        ExpDiff  = (c == 0) ? 8'(v.ed) : 8'($urandom);
        FFOValid = (c == 1) ? v.fv : 1'($urandom);
        FFOIndex = (c == 1) ? 5'(v.fi) : 5'($urandom);
        rm = 25'($urandom);
        if (carry_q[c] >= 0) rm[24] = carry_q[c][0];
        roundedMant = rm;
        Go = (c == n - 1) ? v.chain : 1'($urandom);
    endtask

    task automatic run_op(input vec_t v, input string nm);
        int rdy_at, want;
        model(v);
        want = (v.lat < 0) ? exp_q.size() : v.lat;
        if (v.from_idle) begin
            @(negedge Clock);
            Go = 1'b1;
            #1 check('0, {nm, "_idle"});
        end
        rdy_at = 0;
        for (int c = 0; c < exp_q.size(); c++) begin
            @(negedge Clock);
            drive_cycle(v, c, exp_q.size());
            #1 check(exp_q[c], nm);
            if (Ready === 1'b1 && rdy_at == 0) rdy_at = c + 1;
        end
        n_vec++;
        if (rdy_at != want) begin
            n_err++;
            $display("FAIL %s_latency: Ready at cycle %0d, expected cycle %0d", nm, rdy_at, want);
        end
    endtask

    initial begin
        vec_t v;
        bit   pc;

        tbl[0] = '{1'b1, 1'b1, 'h55, 1'b1, 23, 0, 1'b0, 4};
        tbl[1] = '{1'b1, 1'b0, 3,    1'b1, 22, 0, 1'b0, 4};
        tbl[2] = '{1'b1, 1'b0, 7,    1'b1, 20, 0, 1'b0, 4};
        tbl[3] = '{1'b1, 1'b1, 25,   1'b1, 24, 1, 1'b0, 6};
        tbl[4] = '{1'b1, 1'b0, 26,   1'b1, 0,  2, 1'b1, 8};
        tbl[5] = '{1'b0, 1'b1, 0,    1'b1, 23, 0, 1'b0, 4};
        tbl[6] = '{1'b1, 1'b1, 1,    1'b0, 5,  0, 1'b0, BYP ? 3 : 4};
        tbl[7] = '{1'b1, 1'b0, 24,   1'b1, 30, 0, 1'b0, 4};
        tbl[8] = '{1'b1, 1'b1, 255,  1'b1, 25, 0, 1'b0, 4};
        tbl[9] = '{1'b1, 1'b0, 2,    1'b0, 0,  1, 1'b0, BYP ? 3 : 6};

        #2 Reset = 1'b0;
        @(negedge Clock); #1 check('0, "reset_c1");
        Go = 1'b1;
        @(negedge Clock); #1 check('0, "reset_c2");
        Go = 1'b0;
        Reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock); #1 check('0, "idle_no_go");
        end

        for (int i = 0; i < 10; i++) run_op(tbl[i], $sformatf("tbl%0d", i));

        pc = 1'b0;
        for (int i = 0; i < 40; i++) begin
            v.from_idle = !pc;
            v.es    = 1'($urandom);
            v.ed    = ($urandom % 2) ? int'($urandom_range(0, 30)) : int'($urandom_range(0, 255));
            v.fv    = ($urandom % 8) != 0;
            v.fi    = int'($urandom_range(0, 31));
            v.nc    = int'($urandom_range(0, 3));
            v.chain = (i == 39) ? 1'b0 : 1'($urandom);
            v.lat   = -1;
            pc = v.chain;
            run_op(v, $sformatf("rnd%0d", i));
        end

        // Abort during ROUND: outputs drop at once and no Ready follows.
        v = '{1'b1, 1'b1, 4, 1'b1, 24, 1, 1'b0, -1};
        model(v);
        @(negedge Clock); Go = 1'b1; #1 check('0, "abort_idle");
        for (int c = 0; c < 2; c++) begin
            @(negedge Clock);
            drive_cycle(v, c, exp_q.size());
            #1 check(exp_q[c], "abort_pre");
        end
        @(negedge Clock);
        roundedMant = 25'h1000000;
        Go = 1'b1;
        Reset = 1'b0;
        #1 check('0, "abort_rst");
        @(negedge Clock); #1 check('0, "abort_hold");
        Reset = 1'b1;
        Go = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock); #1 check('0, "abort_after");
        end
        run_op(tbl[0], "recover");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
